// File: rtl/dat_phys_pkg.sv
// Shared definitions for the SD DAT-line transfer engine: default widths and FSM state encoding.
package dat_phys_pkg;

  localparam int unsigned DAT_DATA_W    = 32;
  localparam int unsigned DAT_BLK_CNT_W = 8;
  localparam int unsigned DAT_TIMEOUT_W = 16;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WR_FETCH = 4'd1,
    ST_WR_LOAD  = 4'd2,
    ST_WR_SEND  = 4'd3,
    ST_WR_CRC   = 4'd4,
    ST_WR_BUSY  = 4'd5,
    ST_RD_WAIT  = 4'd6,
    ST_RD_STORE = 4'd7,
    ST_DONE     = 4'd8,
    ST_ERROR    = 4'd9
  } dat_state_e;

  function automatic logic is_terminal(input dat_state_e s);
    return (s == ST_DONE) || (s == ST_ERROR);
  endfunction

endpackage

// File: rtl/dat_timeout_counter.sv
// Cycle counter that flags expiry on the cycle it would reach the programmed limit.
// A limit of zero disables expiry.
module dat_timeout_counter #(
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [TIMEOUT_W-1:0] limit,
  output logic                 expired
);

  logic [TIMEOUT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds the number of cycles already spent, so this is the limit-th counting cycle.
  assign expired = enable && (limit != '0) && (count_q >= (limit - TIMEOUT_W'(1)));

endmodule

// File: rtl/dat_phys_engine.sv
// SD DAT-line transfer engine: sequences FIFO, serialiser wrapper and pad for multi-block
// reads and writes, with CRC-status check, DAT0 busy wait, timeout and abort.
module dat_phys_engine
  import dat_phys_pkg::*;
#(
  parameter int unsigned DATA_W    = DAT_DATA_W,
  parameter int unsigned BLK_CNT_W = DAT_BLK_CNT_W,
  parameter int unsigned TIMEOUT_W = DAT_TIMEOUT_W
) (
  input  logic                 sd_clock,
  input  logic                 reset,
  input  logic                 strobe_in,
  input  logic                 write_read,
  input  logic                 multiple,
  input  logic [BLK_CNT_W-1:0] blocks,
  input  logic [TIMEOUT_W-1:0] timeout_reg,
  input  logic                 idle_in,
  input  logic                 ack_in,
  output logic                 serial_ready,
  output logic                 complete,
  output logic                 ack_out,
  output logic                 data_timeout,
  output logic                 crc_error,
  output logic [BLK_CNT_W-1:0] blocks_done,
  input  logic                 transmission_complete,
  input  logic                 reception_complete,
  input  logic                 crc_status_ok,
  input  logic                 dat0_busy,
  input  logic [DATA_W-1:0]    data_read,
  output logic                 reset_wrapper,
  output logic                 load_send,
  output logic                 enable_pts_wrapper,
  output logic                 enable_stp_wrapper,
  output logic                 waiting_response,
  output logic [DATA_W-1:0]    data_parallel,
  output logic                 pad_state,
  output logic                 pad_enable,
  input  logic                 fifo_empty,
  input  logic                 fifo_full,
  input  logic [DATA_W-1:0]    data_from_fifo,
  output logic                 fifo_pop,
  output logic                 fifo_push,
  output logic [DATA_W-1:0]    data_to_fifo
);

  dat_state_e state_q, state_d;

  logic [BLK_CNT_W-1:0] blocks_q, blocks_d;
  logic [BLK_CNT_W-1:0] blocks_done_q, blocks_done_d;
  logic                 multiple_q, multiple_d;
  logic                 last_q, last_d;
  logic                 data_timeout_q, data_timeout_d;
  logic                 crc_error_q, crc_error_d;
  logic                 serial_ready_q, serial_ready_d;
  logic                 rw_pulse_q, rw_pulse_d;
  logic [DATA_W-1:0]    data_parallel_q, data_parallel_d;
  logic [DATA_W-1:0]    data_to_fifo_q, data_to_fifo_d;

  logic latch_req, inc_blk, set_crc, set_to, ld_tx, ld_rx;
  logic to_enable, to_clear, to_expired;

  logic [BLK_CNT_W:0]   eff_blocks, blk_plus;
  logic [BLK_CNT_W-1:0] blk_sat;
  logic                 inc_last;

  // Block-count arithmetic: one bit wider so the saturation and last-block tests never wrap.
  assign eff_blocks = (blocks_q == '0) ? (BLK_CNT_W+1)'(1) : {1'b0, blocks_q};
  assign blk_plus   = {1'b0, blocks_done_q} + (BLK_CNT_W+1)'(1);
  assign blk_sat    = blk_plus[BLK_CNT_W] ? blocks_done_q : blk_plus[BLK_CNT_W-1:0];
  assign inc_last   = !multiple_q || (blk_plus == eff_blocks);

  assign to_enable = (state_q == ST_WR_CRC) || (state_q == ST_RD_WAIT) ||
                     ((state_q == ST_WR_BUSY) && dat0_busy);
  assign to_clear  = (state_d != state_q);

  dat_timeout_counter #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_timeout (
    .clk     (sd_clock),
    .rst_n   (reset),
    .clear   (to_clear),
    .enable  (to_enable),
    .limit   (timeout_reg),
    .expired (to_expired)
  );

  always_comb begin
    state_d    = state_q;
    latch_req  = 1'b0;
    inc_blk    = 1'b0;
    set_crc    = 1'b0;
    set_to     = 1'b0;
    ld_tx      = 1'b0;
    ld_rx      = 1'b0;
    rw_pulse_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (strobe_in) begin
          latch_req = 1'b1;
          state_d   = write_read ? ST_WR_FETCH : ST_RD_WAIT;
        end
      end
      ST_WR_FETCH: if (!fifo_empty) state_d = ST_WR_LOAD;
      ST_WR_LOAD: begin
        ld_tx   = 1'b1;
        state_d = ST_WR_SEND;
      end
      ST_WR_SEND: if (transmission_complete) state_d = ST_WR_CRC;
      ST_WR_CRC: begin
        if (reception_complete) begin
          if (crc_status_ok) begin
            inc_blk = 1'b1;
            state_d = ST_WR_BUSY;
          end else begin
            set_crc = 1'b1;
            state_d = ST_ERROR;
          end
        end else if (to_expired) begin
          set_to  = 1'b1;
          state_d = ST_ERROR;
        end
      end
      ST_WR_BUSY: begin
        if (!dat0_busy) begin
          if (last_q) begin
            state_d = ST_DONE;
          end else begin
            rw_pulse_d = 1'b1;
            state_d    = ST_WR_FETCH;
          end
        end else if (to_expired) begin
          set_to  = 1'b1;
          state_d = ST_ERROR;
        end
      end
      ST_RD_WAIT: begin
        if (reception_complete) begin
          ld_rx   = 1'b1;
          state_d = ST_RD_STORE;
        end else if (to_expired) begin
          set_to  = 1'b1;
          state_d = ST_ERROR;
        end
      end
      ST_RD_STORE: begin
        if (!fifo_full) begin
          inc_blk = 1'b1;
          if (inc_last) begin
            state_d = ST_DONE;
          end else begin
            rw_pulse_d = 1'b1;
            state_d    = ST_RD_WAIT;
          end
        end
      end
      ST_DONE, ST_ERROR: if (ack_in) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Abort overrides every transition and every side effect of this cycle.
    if (idle_in) begin
      state_d    = ST_IDLE;
      latch_req  = 1'b0;
      inc_blk    = 1'b0;
      set_crc    = 1'b0;
      set_to     = 1'b0;
      ld_tx      = 1'b0;
      ld_rx      = 1'b0;
      rw_pulse_d = 1'b0;
    end
  end

  always_comb begin
    blocks_d        = blocks_q;
    multiple_d      = multiple_q;
    blocks_done_d   = blocks_done_q;
    last_d          = last_q;
    data_timeout_d  = data_timeout_q;
    crc_error_d     = crc_error_q;
    data_parallel_d = data_parallel_q;
    data_to_fifo_d  = data_to_fifo_q;
    serial_ready_d  = (state_d == ST_IDLE);
    if (latch_req) begin
      blocks_d       = blocks;
      multiple_d     = multiple;
      blocks_done_d  = '0;
      last_d         = 1'b0;
      data_timeout_d = 1'b0;
      crc_error_d    = 1'b0;
    end
    if (inc_blk) begin
      blocks_done_d = blk_sat;
      last_d        = inc_last;
    end
    if (set_crc) crc_error_d     = 1'b1;
    if (set_to)  data_timeout_d  = 1'b1;
    if (ld_tx)   data_parallel_d = data_from_fifo;
    if (ld_rx)   data_to_fifo_d  = data_read;
  end

  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      blocks_q        <= '0;
      multiple_q      <= 1'b0;
      blocks_done_q   <= '0;
      last_q          <= 1'b0;
      data_timeout_q  <= 1'b0;
      crc_error_q     <= 1'b0;
      serial_ready_q  <= 1'b0;
      rw_pulse_q      <= 1'b0;
      data_parallel_q <= '0;
      data_to_fifo_q  <= '0;
    end else begin
      state_q         <= state_d;
      blocks_q        <= blocks_d;
      multiple_q      <= multiple_d;
      blocks_done_q   <= blocks_done_d;
      last_q          <= last_d;
      data_timeout_q  <= data_timeout_d;
      crc_error_q     <= crc_error_d;
      serial_ready_q  <= serial_ready_d;
      rw_pulse_q      <= rw_pulse_d;
      data_parallel_q <= data_parallel_d;
      data_to_fifo_q  <= data_to_fifo_d;
    end
  end

  always_comb begin
    load_send          = 1'b0;
    enable_pts_wrapper = 1'b0;
    enable_stp_wrapper = 1'b0;
    waiting_response   = 1'b0;
    pad_state          = 1'b0;
    pad_enable         = 1'b0;
    complete           = 1'b0;
    unique case (state_q)
      ST_WR_LOAD: begin
        pad_state  = 1'b1;
        pad_enable = 1'b1;
      end
      ST_WR_SEND: begin
        load_send          = 1'b1;
        enable_pts_wrapper = 1'b1;
        pad_state          = 1'b1;
        pad_enable         = 1'b1;
      end
      ST_WR_CRC: begin
        pad_enable         = 1'b1;
        enable_stp_wrapper = 1'b1;
        waiting_response   = 1'b1;
      end
      ST_WR_BUSY: pad_enable = 1'b1;
      ST_RD_WAIT, ST_RD_STORE: begin
        pad_enable         = 1'b1;
        enable_stp_wrapper = 1'b1;
      end
      ST_DONE, ST_ERROR: complete = 1'b1;
      default: ;
    endcase
  end

  // IDLE is the reset state, so these are zero during reset apart from reset_wrapper.
  assign reset_wrapper = (state_q == ST_IDLE) || is_terminal(state_q) || rw_pulse_q;
  assign fifo_pop      = (state_q == ST_WR_FETCH) && !fifo_empty && !idle_in;
  assign fifo_push     = (state_q == ST_RD_STORE) && !fifo_full && !idle_in;
  assign ack_out       = complete && ack_in;
  assign serial_ready  = serial_ready_q;
  assign data_timeout  = data_timeout_q;
  assign crc_error     = crc_error_q;
  assign blocks_done   = blocks_done_q;
  assign data_parallel = data_parallel_q;
  assign data_to_fifo  = data_to_fifo_q;

endmodule

// File: tb/tb_dat_phys_engine.sv
// Directed plus randomized bench for dat_phys_engine with a transfer-level reference model.
module tb_dat_phys_engine;

  logic        sd_clock = 1'b0;
  logic        reset = 1'b0;
  logic        strobe_in = 1'b0, write_read = 1'b0, multiple = 1'b0;
  logic [7:0]  blocks = '0;
  logic [15:0] timeout_reg = '0;
  logic        idle_in = 1'b0, ack_in = 1'b0;
  logic        serial_ready, complete, ack_out, data_timeout, crc_error;
  logic [7:0]  blocks_done;
  logic        transmission_complete = 1'b0, reception_complete = 1'b0;
  logic        crc_status_ok = 1'b0, dat0_busy = 1'b0;
  logic [31:0] data_read = '0;
  logic        reset_wrapper, load_send, enable_pts_wrapper, enable_stp_wrapper;
  logic        waiting_response, pad_state, pad_enable;
  logic [31:0] data_parallel;
  logic        fifo_empty = 1'b1, fifo_full = 1'b0;
  logic [31:0] data_from_fifo = '0;
  logic        fifo_pop, fifo_push;
  logic [31:0] data_to_fifo;

  int          errors = 0;
  int          checks = 0;
  int unsigned pop_count = 0;
  logic [31:0] push_q[$];

  dat_phys_engine #(.DATA_W(32), .BLK_CNT_W(8), .TIMEOUT_W(16)) dut (
    .sd_clock(sd_clock), .reset(reset), .strobe_in(strobe_in), .write_read(write_read),
    .multiple(multiple), .blocks(blocks), .timeout_reg(timeout_reg), .idle_in(idle_in),
    .ack_in(ack_in), .serial_ready(serial_ready), .complete(complete), .ack_out(ack_out),
    .data_timeout(data_timeout), .crc_error(crc_error), .blocks_done(blocks_done),
    .transmission_complete(transmission_complete), .reception_complete(reception_complete),
    .crc_status_ok(crc_status_ok), .dat0_busy(dat0_busy), .data_read(data_read),
    .reset_wrapper(reset_wrapper), .load_send(load_send),
    .enable_pts_wrapper(enable_pts_wrapper), .enable_stp_wrapper(enable_stp_wrapper),
    .waiting_response(waiting_response), .data_parallel(data_parallel),
    .pad_state(pad_state), .pad_enable(pad_enable), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .data_from_fifo(data_from_fifo), .fifo_pop(fifo_pop),
    .fifo_push(fifo_push), .data_to_fifo(data_to_fifo)
  );

  always #5 sd_clock = ~sd_clock;

  always @(negedge sd_clock) begin
    if (fifo_pop)  pop_count++;
    if (fifo_push) push_q.push_back(data_to_fifo);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge sd_clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned model_blocks(input int unsigned req, input bit mult);
    if (!mult) return 1;
    return (req == 0) ? 1 : req;
  endfunction

  task automatic start(input bit wr, input int unsigned nblk, input bit mult);
    write_read = wr; blocks = 8'(nblk); multiple = mult; strobe_in = 1'b1;
    step();
    strobe_in = 1'b0;
    #1;
    check("start_flags_clear", {data_timeout, crc_error, serial_ready}, 0);
    check("start_blocks_done_zero", blocks_done, 0);
  endtask

  task automatic acknowledge();
    ack_in = 1'b1;
    #1;
    check("ack_out_echo", ack_out, 1);
    step();
    ack_in = 1'b0;
    #1;
    check("ack_back_to_idle", {serial_ready, complete}, 2'b10);
  endtask

  task automatic do_write(input int unsigned nblk, input bit mult, input int unsigned fail_blk,
                          input int unsigned stall, input int unsigned busy_fixed,
                          input logic [31:0] fixed_word);
    int unsigned eff, pops0, done, n, bc;
    bit          failed;
    logic [31:0] w;
    eff = model_blocks(nblk, mult);
    pops0 = pop_count; done = 0; failed = 0;
    fifo_empty = 1'b1;
    start(1'b1, nblk, mult);
    if (stall != 0) begin
      repeat (stall) step();
      check("wr_stall_no_pop", pop_count, pops0);
      check("wr_stall_no_timeout", {data_timeout, complete}, 0);
    end
    for (int unsigned b = 1; b <= eff && !failed; b++) begin
      w = (fixed_word != 0) ? fixed_word : $urandom;
      fifo_empty = 1'b0;
      #1;
      n = 0;
      while (!fifo_pop && n < 50) begin step(); n++; end
      check("wr_pop_seen", fifo_pop, 1);
      step();
      fifo_empty = 1'b1; data_from_fifo = w;
      step();
      check("wr_data_parallel", data_parallel, w);
      check("wr_send_pad", {load_send, enable_pts_wrapper, pad_state, pad_enable}, 4'hF);
      repeat ($urandom_range(0, 3)) step();
      transmission_complete = 1'b1;
      step();
      transmission_complete = 1'b0;
      check("wr_crc_wait", {waiting_response, pad_state, pad_enable}, 3'b101);
      repeat ($urandom_range(0, 4)) step();
      reception_complete = 1'b1; crc_status_ok = (b != fail_blk);
      step();
      reception_complete = 1'b0; crc_status_ok = 1'b0;
      if (b == fail_blk) begin
        failed = 1;
        #1;
        check("wr_crc_error_flag", {crc_error, complete}, 2'b11);
        check("wr_crc_error_blocks", blocks_done, done);
      end else begin
        done++;
        check("wr_blocks_done", blocks_done, done);
        bc = (busy_fixed != 0) ? busy_fixed : $urandom_range(1, 6);
        dat0_busy = 1'b1;
        repeat (bc) begin
          step();
          check("wr_busy_not_complete", complete, 0);
        end
        dat0_busy = 1'b0;
        step();
      end
    end
    if (!failed) begin
      check("wr_complete", {complete, crc_error, data_timeout}, 3'b100);
      check("wr_final_blocks", blocks_done, eff);
    end
    check("wr_pop_total", pop_count - pops0, failed ? fail_blk : eff);
    acknowledge();
  endtask

  task automatic do_read(input int unsigned nblk, input bit mult, input int unsigned full_max);
    int unsigned eff, base, st;
    logic [31:0] exp_q[$];
    logic [31:0] w;
    eff = model_blocks(nblk, mult);
    base = push_q.size();
    start(1'b0, nblk, mult);
    for (int unsigned b = 1; b <= eff; b++) begin
      repeat ($urandom_range(0, 5)) step();
      check("rd_wait_no_push", fifo_push, 0);
      w = $urandom;
      data_read = w; reception_complete = 1'b1;
      st = $urandom_range(0, full_max);
      fifo_full = (st != 0);
      step();
      reception_complete = 1'b0;
      if (st != 0) begin
        repeat (st) begin
          check("rd_full_no_push", fifo_push, 0);
          step();
        end
        fifo_full = 1'b0;
        #1;
      end
      check("rd_push", fifo_push, 1);
      check("rd_data_to_fifo", data_to_fifo, w);
      exp_q.push_back(w);
      step();
    end
    check("rd_complete", complete, 1);
    check("rd_final_blocks", blocks_done, eff);
    check("rd_push_total", push_q.size() - base, eff);
    for (int unsigned i = 0; i < exp_q.size() && base + i < push_q.size(); i++)
      check("rd_push_data", push_q[base + i], exp_q[i]);
    acknowledge();
  endtask

  initial begin
    int unsigned c, pushes0;
    #12;
    check("reset_outputs", {serial_ready, complete, ack_out, data_timeout, crc_error,
                            load_send, enable_pts_wrapper, enable_stp_wrapper,
                            waiting_response, pad_state, pad_enable, fifo_pop, fifo_push}, 0);
    check("reset_wrapper_in_reset", reset_wrapper, 1);
    check("reset_data", {data_parallel, data_to_fifo, blocks_done}, 0);
    reset = 1'b1;
    timeout_reg = 16'd1000;
    step();
    check("ready_after_reset", serial_ready, 1);

    // single-block write with a fixed FIFO word and 10 busy cycles
    do_write(1, 1'b0, 0, 0, 10, 32'hA5A5_5A5A);
    // three-block read with FIFO back-pressure
    do_read(3, 1'b1, 3);
    // FIFO empty for 20 cycles under a short timeout: fetching must not time out
    timeout_reg = 16'd8;
    do_write(1, 1'b0, 0, 20, 3, 32'h0);

    // read timeout: flag rises exactly 16 cycles into RD_WAIT
    timeout_reg = 16'd16;
    start(1'b0, 1, 1'b0);
    c = 0;
    while (!data_timeout && c < 100) begin step(); c++; end
    check("rd_timeout_cycles", c, 16);
    check("rd_timeout_error", {data_timeout, complete, crc_error}, 3'b110);
    acknowledge();

    // CRC failure on block 2 of 4
    timeout_reg = 16'd1000;
    do_write(4, 1'b1, 2, 0, 0, 32'h0);

    // timeout disabled, then abort
    timeout_reg = 16'd0;
    start(1'b0, 1, 1'b0);
    repeat (40) step();
    check("no_timeout_when_disabled", {data_timeout, complete}, 0);
    idle_in = 1'b1;
    step();
    idle_in = 1'b0;
    #1;
    check("abort_to_idle", {serial_ready, enable_stp_wrapper, complete}, 3'b100);

    // randomized transfers, including blocks=0 and non-multiple with blocks>1
    timeout_reg = 16'd1000;
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 1) != 0)
        do_write($urandom_range(0, 3), 1'($urandom_range(0, 1)), 0, 0, 0, 32'h0);
      else
        do_read($urandom_range(0, 3), 1'($urandom_range(0, 1)), 2);
    end

    // asynchronous reset while stalled in RD_STORE
    pushes0 = push_q.size();
    start(1'b0, 2, 1'b1);
    step();
    data_read = 32'hDEAD_BEEF; reception_complete = 1'b1; fifo_full = 1'b1;
    step();
    reception_complete = 1'b0;
    repeat (3) step();
    check("store_stalled", fifo_push, 0);
    #2;
    reset = 1'b0;
    #1;
    check("midreset_outputs", {serial_ready, complete, enable_stp_wrapper, pad_enable,
                               fifo_push, fifo_pop, data_timeout, crc_error}, 0);
    check("midreset_regs", {blocks_done, data_to_fifo, data_parallel}, 0);
    check("midreset_wrapper", reset_wrapper, 1);
    step();
    step();
    fifo_full = 1'b0;
    reset = 1'b1;
    step();
    check("after_midreset_idle", {serial_ready, complete}, 2'b10);
    check("midreset_no_push", push_q.size(), pushes0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
